avalon_st_seq_source: RTL and testbench

AVALON_ST_SEQ_SOURCE -- requirements
Module: avalon_st_seq_source

---
 rtl/avalon_pkg.sv | 16 +
 rtl/avalon_st_beat_ctr.sv | 44 ++++
 rtl/avalon_st_seq_source.sv | 158 +++++++++++++++
 tb/tb_avalon_st_seq_source.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_pkg.sv
// Shared definitions for the Avalon-ST sequence source: FSM encoding and
// the legal parameter ranges checked at elaboration.
package avalon_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StSend = 2'd1,
      StWrap = 2'd2
   } state_e;

   localparam int unsigned DataWMin    = 1;
   localparam int unsigned DataWMax    = 32;
   localparam int unsigned NumBeatsMin = 1;
   localparam int unsigned NumBeatsMax = 255;

endpackage

// File: rtl/avalon_st_beat_ctr.sv
// Beat index within a packet plus terminal-count decode. Wraps to 0 when the
// last beat is advanced past, so back-to-back packets need no extra clear.
module avalon_st_beat_ctr #(
   parameter int unsigned NUM_BEATS = 3,
   localparam int unsigned CntW     = $clog2(NUM_BEATS + 1)
) (
   input  logic            clk,
   input  logic            resetn,
   input  logic            advance_i,
   input  logic            clear_i,
   output logic [CntW-1:0] index_o,
   output logic            last_o
);

   localparam logic [CntW-1:0] LastIdx = CntW'(NUM_BEATS - 1);

   logic [CntW-1:0] idx_q, idx_d;

   // Next index: clear wins, otherwise step and wrap on the terminal beat.
   always_comb begin
      idx_d = idx_q;
      if (clear_i) begin
         idx_d = '0;
      end else if (advance_i) begin
         idx_d = (idx_q == LastIdx) ? '0 : idx_q + CntW'(1);
      end
   end

   // Index register, asynchronously cleared.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         idx_q <= '0;
      end else begin
         idx_q <= idx_d;
      end
   end

   assign index_o = idx_q;
   assign last_o  = (idx_q == LastIdx);

   // The index never runs past the final beat.
   assert property (@(posedge clk) disable iff (!resetn) idx_q <= LastIdx);

endmodule

// File: rtl/avalon_st_seq_source.sv
// Avalon-ST source emitting packets of an arithmetic sequence. Every output
// is a flop; ready only steers the next-state logic, never valid directly.
module avalon_st_seq_source
   import avalon_pkg::*;
#(
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned FIRST_VAL = 4,
   parameter int unsigned STEP      = 1,
   parameter int unsigned NUM_BEATS = 3,
   parameter int unsigned REPEAT    = 0
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              start_i,
   input  logic              ready_i,
   output logic              valid_o,
   output logic [DATA_W-1:0] data_o,
   output logic              sop_o,
   output logic              eop_o,
   output logic              busy_o,
   output logic              done_o
);

   localparam int unsigned        CntW     = $clog2(NUM_BEATS + 1);
   localparam logic [DATA_W-1:0]  FirstV   = DATA_W'(FIRST_VAL);
   localparam logic [DATA_W-1:0]  StepV    = DATA_W'(STEP);
   localparam logic               FirstEop = (NUM_BEATS == 1);

   if (DATA_W < DataWMin || DATA_W > DataWMax) begin : g_bad_data_w
      $error("DATA_W outside legal range");
   end
   if (NUM_BEATS < NumBeatsMin || NUM_BEATS > NumBeatsMax) begin : g_bad_num_beats
      $error("NUM_BEATS outside legal range");
   end

   state_e            state_q, state_d;
   logic              valid_q, valid_d;
   logic [DATA_W-1:0] data_q, data_d;
   logic              sop_q, sop_d;
   logic              eop_q, eop_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;

   logic              transfer;
   logic [CntW-1:0]   beat_idx;
   logic              beat_last;
   logic              next_last;
   logic              carry;
   logic [DATA_W-1:0] sum;
   logic              overflow_flag;

   assign transfer = valid_q && ready_i;
   assign {carry, sum} = {1'b0, data_q} + {1'b0, StepV};
   assign next_last = (32'(beat_idx) + 32'd1) == (NUM_BEATS - 1);
   assign overflow_flag = (state_q == StWrap);

   avalon_st_beat_ctr #(
      .NUM_BEATS(NUM_BEATS)
   ) u_beat_ctr (
      .clk      (clk),
      .resetn   (resetn),
      .advance_i(transfer),
      .clear_i  (state_q == StIdle),
      .index_o  (beat_idx),
      .last_o   (beat_last)
   );

   // Next state and next registered outputs; registers hold unless changed.
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      data_d  = data_q;
      sop_d   = sop_q;
      eop_d   = eop_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               state_d = StSend;
               valid_d = 1'b1;
               data_d  = FirstV;
               sop_d   = 1'b1;
               eop_d   = FirstEop;
               busy_d  = 1'b1;
            end
         end
         StSend, StWrap: begin
            if (transfer) begin
               if (beat_last) begin
                  done_d = 1'b1;
                  if (REPEAT != 0) begin
                     state_d = StSend;
                     data_d  = FirstV;
                     sop_d   = 1'b1;
                     eop_d   = FirstEop;
                  end else begin
                     state_d = StIdle;
                     valid_d = 1'b0;
                     sop_d   = 1'b0;
                     eop_d   = 1'b0;
                     busy_d  = 1'b0;
                  end
               end else begin
                  // Wrap state only marks that this beat's data rolled over.
                  state_d = carry ? StWrap : StSend;
                  data_d  = sum;
                  sop_d   = 1'b0;
                  eop_d   = next_last;
               end
            end
         end
         default: begin
            state_d = StIdle;
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
            busy_d  = 1'b0;
         end
      endcase
   end

   // State and output registers, asynchronously forced to idle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= StIdle;
         valid_q <= 1'b0;
         data_q  <= '0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         data_q  <= data_d;
         sop_q   <= sop_d;
         eop_q   <= eop_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign sop_o   = sop_q;
   assign eop_o   = eop_q;
   assign busy_o  = busy_q;
   assign done_o  = done_q;

   // A stalled beat holds still until the sink takes it.
   assert property (@(posedge clk) disable iff (!resetn)
      valid_q && !ready_i |=> valid_q && $stable(data_q) && $stable(sop_q) && $stable(eop_q));

   // The overflow state is only ever a mid-packet beat.
   assert property (@(posedge clk) disable iff (!resetn) overflow_flag |-> valid_q && !sop_q);

endmodule

// File: tb/tb_avalon_st_seq_source.sv
// Bench for avalon_st_seq_source: four configurations share one stimulus
// stream; a packet-level model queues expected beats, a monitor pops them.
module tb_avalon_st_seq_source;

   localparam int NDut = 4;
   // Per-instance configuration: data width, first value, step, beats, repeat.
   localparam int PDw    [NDut] = '{8, 4, 8, 8};
   localparam int PFirst [NDut] = '{4, 14, 4, 4};
   localparam int PStep  [NDut] = '{1, 1, 1, 1};
   localparam int PNb    [NDut] = '{3, 4, 2, 1};
   localparam int PRep   [NDut] = '{0, 0, 1, 0};

   typedef struct {
      longint data;
      bit     sop;
      bit     eop;
   } beat_t;

   logic clk;
   logic resetn;
   logic start;
   logic ready;

   logic [NDut-1:0] valid_w, sop_w, eop_w, busy_w, done_w;
   logic [7:0]      data0, data2, data3;
   logic [3:0]      data1;
   logic [31:0]     data_w [NDut];

   assign data_w[0] = 32'(data0);
   assign data_w[1] = 32'(data1);
   assign data_w[2] = 32'(data2);
   assign data_w[3] = 32'(data3);

   int tests_run = 0;
   int fails     = 0;

   // Model state: beats still owed in the current packet, expected done pulse.
   int    remaining [NDut];
   bit    done_exp  [NDut];
   beat_t exp_q     [NDut][$];

   // Monitor history for the stall-stability rule.
   bit     prev_hold  [NDut];
   longint prev_data  [NDut];
   bit     prev_sop   [NDut];
   bit     prev_eop   [NDut];

   avalon_st_seq_source #(
      .DATA_W(8), .FIRST_VAL(4), .STEP(1), .NUM_BEATS(3), .REPEAT(0)
   ) u_dut0 (
      .clk(clk), .resetn(resetn), .start_i(start), .ready_i(ready),
      .valid_o(valid_w[0]), .data_o(data0), .sop_o(sop_w[0]), .eop_o(eop_w[0]),
      .busy_o(busy_w[0]), .done_o(done_w[0])
   );

   avalon_st_seq_source #(
      .DATA_W(4), .FIRST_VAL(14), .STEP(1), .NUM_BEATS(4), .REPEAT(0)
   ) u_dut1 (
      .clk(clk), .resetn(resetn), .start_i(start), .ready_i(ready),
      .valid_o(valid_w[1]), .data_o(data1), .sop_o(sop_w[1]), .eop_o(eop_w[1]),
      .busy_o(busy_w[1]), .done_o(done_w[1])
   );

   avalon_st_seq_source #(
      .DATA_W(8), .FIRST_VAL(4), .STEP(1), .NUM_BEATS(2), .REPEAT(1)
   ) u_dut2 (
      .clk(clk), .resetn(resetn), .start_i(start), .ready_i(ready),
      .valid_o(valid_w[2]), .data_o(data2), .sop_o(sop_w[2]), .eop_o(eop_w[2]),
      .busy_o(busy_w[2]), .done_o(done_w[2])
   );

   avalon_st_seq_source #(
      .DATA_W(8), .FIRST_VAL(4), .STEP(1), .NUM_BEATS(1), .REPEAT(0)
   ) u_dut3 (
      .clk(clk), .resetn(resetn), .start_i(start), .ready_i(ready),
      .valid_o(valid_w[3]), .data_o(data3), .sop_o(sop_w[3]), .eop_o(eop_w[3]),
      .busy_o(busy_w[3]), .done_o(done_w[3])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input longint act, input longint exp);
      tests_run++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Queue every beat of one packet: value k is first + k*step, wrapped.
   task automatic push_packet(input int i);
      beat_t b;
      for (int k = 0; k < PNb[i]; k++) begin
         b.data = (longint'(PFirst[i]) + longint'(k) * PStep[i]) % (longint'(1) << PDw[i]);
         b.sop  = (k == 0);
         b.eop  = (k == PNb[i] - 1);
         exp_q[i].push_back(b);
      end
   endtask

   // Packet-level model: a start taken while idle owes NUM_BEATS beats, each
   // accepted by a ready cycle; the last one raises done and, if repeating,
   // immediately owes another packet.
   always @(posedge clk or negedge resetn) begin : model
      int  r;
      bit  d;
      if (!resetn) begin
         for (int i = 0; i < NDut; i++) begin
            remaining[i] <= 0;
            done_exp[i]  <= 1'b0;
            exp_q[i].delete();
         end
      end else begin
         for (int i = 0; i < NDut; i++) begin
            r = remaining[i];
            d = 1'b0;
            if (r > 0) begin
               if (ready) begin
                  r = r - 1;
                  if (r == 0) begin
                     d = 1'b1;
                     if (PRep[i] != 0) begin
                        push_packet(i);
                        r = PNb[i];
                     end
                  end
               end
            end else if (start) begin
               push_packet(i);
               r = PNb[i];
            end
            remaining[i] <= r;
            done_exp[i]  <= d;
         end
      end
   end

   // Monitor: mid-cycle comparison of every instance against the model.
   always @(negedge clk) begin : monitor
      beat_t b;
      for (int i = 0; i < NDut; i++) begin
         if (!resetn) begin
            check($sformatf("d%0d reset valid", i), longint'(valid_w[i]), 0);
            check($sformatf("d%0d reset data", i), longint'(data_w[i]), 0);
            check($sformatf("d%0d reset sop", i), longint'(sop_w[i]), 0);
            check($sformatf("d%0d reset eop", i), longint'(eop_w[i]), 0);
            check($sformatf("d%0d reset busy", i), longint'(busy_w[i]), 0);
            check($sformatf("d%0d reset done", i), longint'(done_w[i]), 0);
            prev_hold[i] = 1'b0;
         end else begin
            check($sformatf("d%0d valid", i), longint'(valid_w[i]), longint'(remaining[i] > 0));
            check($sformatf("d%0d busy", i), longint'(busy_w[i]), longint'(remaining[i] > 0));
            check($sformatf("d%0d done", i), longint'(done_w[i]), longint'(done_exp[i]));
            if (prev_hold[i]) begin
               check($sformatf("d%0d stall data", i), longint'(data_w[i]), prev_data[i]);
               check($sformatf("d%0d stall sop", i), longint'(sop_w[i]), longint'(prev_sop[i]));
               check($sformatf("d%0d stall eop", i), longint'(eop_w[i]), longint'(prev_eop[i]));
            end
            if (valid_w[i] && ready) begin
               if (exp_q[i].size() == 0) begin
                  check($sformatf("d%0d unexpected beat", i), 1, 0);
               end else begin
                  b = exp_q[i].pop_front();
                  check($sformatf("d%0d data", i), longint'(data_w[i]), b.data);
                  check($sformatf("d%0d sop", i), longint'(sop_w[i]), longint'(b.sop));
                  check($sformatf("d%0d eop", i), longint'(eop_w[i]), longint'(b.eop));
               end
            end
            prev_hold[i] = valid_w[i] && !ready;
            prev_data[i] = longint'(data_w[i]);
            prev_sop[i]  = sop_w[i];
            prev_eop[i]  = eop_w[i];
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   initial begin
      resetn = 1'b0;
      start  = 1'b0;
      ready  = 1'b1;
      repeat (3) step();
      resetn = 1'b1;
      step();

      // Plain packet with ready held high.
      pulse_start();
      repeat (8) step();

      // Stall the sink for two cycles while the second beat is presented.
      pulse_start();
      step();
      ready = 1'b0;
      repeat (2) step();
      ready = 1'b1;
      repeat (8) step();

      // Reset in the middle of a packet, then a fresh packet.
      pulse_start();
      step();
      #1;
      resetn = 1'b0;
      #1;
      check("async reset drops valid", longint'(valid_w[0]), 0);
      step();
      resetn = 1'b1;
      pulse_start();
      repeat (8) step();

      // Start held across a busy cycle; the second request must be ignored.
      start = 1'b1;
      repeat (2) step();
      start = 1'b0;
      repeat (8) step();

      // Randomised traffic with occasional resets.
      for (int c = 0; c < 3000; c++) begin
         ready  = ($urandom_range(3) != 0);
         start  = ($urandom_range(5) == 0);
         resetn = ($urandom_range(299) != 0);
         step();
      end

      // Drain and confirm nothing is still owed by the one-shot instances.
      resetn = 1'b1;
      start  = 1'b0;
      ready  = 1'b1;
      repeat (20) step();
      for (int i = 0; i < NDut; i++) begin
         if (PRep[i] == 0) begin
            check($sformatf("d%0d beats left", i), longint'(exp_q[i].size()), 0);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
